// File: rtl/pulp_io_gpio_event.sv
// pulp_io_gpio_event: per-channel two-flop synchroniser, debounce filter and sticky edge/level event status.
// Define PULP_IO_GPIO_DEBOUNCE_EN to build the debounce counters; otherwise the filter passes sync_q straight through.
module pulp_io_gpio_event #(
    parameter int NUM_GPIO   = 32,
    parameter int DEBOUNCE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_GPIO-1:0]   gpio_i,
    input  logic [NUM_GPIO-1:0]   en_i,
    input  logic [NUM_GPIO-1:0]   irq_en_i,
    input  logic [2*NUM_GPIO-1:0] irq_type_i,
    input  logic [DEBOUNCE_W-1:0] debounce_cnt_i,
    input  logic [NUM_GPIO-1:0]   irq_clr_i,
    output logic [NUM_GPIO-1:0]   gpio_o,
    output logic [NUM_GPIO-1:0]   irq_status_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        EV_FALL  = 2'b00,
        EV_RISE  = 2'b01,
        EV_BOTH  = 2'b10,
        EV_LEVEL = 2'b11
    } ev_type_e;

    logic [NUM_GPIO-1:0] r_sync1;
    logic [NUM_GPIO-1:0] r_sync;
    logic [NUM_GPIO-1:0] r_stable;
    logic [NUM_GPIO-1:0] r_status;
    logic [NUM_GPIO-1:0] w_stable_nxt;
    logic [NUM_GPIO-1:0] w_event;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync  <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync  <= r_sync1;
        end
    end

`ifdef PULP_IO_GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] r_cnt     [NUM_GPIO];
    logic [DEBOUNCE_W-1:0] w_cnt_nxt [NUM_GPIO];

    // >= rather than == so a threshold lowered mid-filter still accepts at once.
    always_comb begin
        for (int k = 0; k < NUM_GPIO; k++) begin
            w_stable_nxt[k] = r_stable[k];
            w_cnt_nxt[k]    = '0;
            if (en_i[k] && (r_sync[k] != r_stable[k])) begin
                if (r_cnt[k] >= debounce_cnt_i) begin
                    w_stable_nxt[k] = r_sync[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end
`else
    logic w_unused_dbc;
    assign w_unused_dbc = ^debounce_cnt_i;
    assign w_stable_nxt = (r_sync & en_i) | (r_stable & ~en_i);
`endif

    // Edge events look at the transition being committed this cycle; level looks at the held value.
    always_comb begin
        w_event = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            case (ev_type_e'(irq_type_i[2*k +: 2]))
                EV_FALL:  w_event[k] = r_stable[k] & ~w_stable_nxt[k];
                EV_RISE:  w_event[k] = ~r_stable[k] & w_stable_nxt[k];
                EV_BOTH:  w_event[k] = r_stable[k] ^ w_stable_nxt[k];
                EV_LEVEL: w_event[k] = r_stable[k] & en_i[k];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stable <= '0;
            r_status <= '0;
        end else begin
            r_stable <= w_stable_nxt;
            r_status <= w_event | (r_status & ~irq_clr_i);
        end
    end

    assign gpio_o       = r_stable;
    assign irq_status_o = r_status;
    assign irq_o        = |(r_status & irq_en_i);

endmodule

// File: tb/tb_pulp_io_gpio_event.sv
// tb_pulp_io_gpio_event: directed and randomized checks of pulp_io_gpio_event against a behavioural model.
module tb_pulp_io_gpio_event;
  localparam int N  = 32;
  localparam int DW = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] gpio;
  logic [N-1:0] en;
  logic [N-1:0] irq_en;
  logic [N-1:0] clr;
  logic [2*N-1:0] typ;
  logic [DW-1:0]  dbc;
  logic [N-1:0] gpio_o;
  logic [N-1:0] irq_status_o;
  logic         irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pulp_io_gpio_event #(.NUM_GPIO(N), .DEBOUNCE_W(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .gpio_i         (gpio),
    .en_i           (en),
    .irq_en_i       (irq_en),
    .irq_type_i     (typ),
    .debounce_cnt_i (dbc),
    .irq_clr_i      (clr),
    .gpio_o         (gpio_o),
    .irq_status_o   (irq_status_o),
    .irq_o          (irq_o)
  );

  // Reference model: input delayed two cycles, then a channel adopts the delayed value once it
  // has disagreed with the accepted value for more than D consecutive enabled cycles.
  logic [N-1:0] m_sync1, m_sync, m_stable, m_status;
  int           m_run [N];

  function automatic int d_eff(input logic [DW-1:0] d);
`ifdef PULP_IO_GPIO_DEBOUNCE_EN
    return int'(d);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_sync1  = '0;
    m_sync   = '0;
    m_stable = '0;
    m_status = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] nstable;
    logic [N-1:0] ev;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d = d_eff(dbc);
    nstable = m_stable;
    ev = '0;
    for (int k = 0; k < N; k++) begin
      if (en[k] && (m_sync[k] != m_stable[k])) begin
        if (m_run[k] >= d) begin
          nstable[k] = m_sync[k];
          m_run[k] = 0;
        end else begin
          m_run[k] = m_run[k] + 1;
        end
      end else begin
        m_run[k] = 0;
      end
      case (typ[2*k +: 2])
        2'b00:   ev[k] = m_stable[k] && !nstable[k];
        2'b01:   ev[k] = !m_stable[k] && nstable[k];
        2'b10:   ev[k] = m_stable[k] != nstable[k];
        default: ev[k] = m_stable[k] && en[k];
      endcase
    end
    m_status = ev | (m_status & ~clr);
    m_stable = nstable;
    m_sync   = m_sync1;
    m_sync1  = gpio;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("gpio_o", 64'(gpio_o), 64'(m_stable));
    check("irq_status_o", 64'(irq_status_o), 64'(m_status));
    check("irq_o", 64'(irq_o), 64'(|(m_status & irq_en)));
  endtask

  task automatic set_type(input int k, input logic [1:0] t);
    typ[2*k +: 2] = t;
  endtask

  initial begin
    int de;
    gpio   = '0;
    en     = '1;
    irq_en = '0;
    clr    = '0;
    dbc    = '0;
    typ    = {N{2'b01}};
    model_reset();

    // Reset state
    #1;
    check("reset_gpio_o", 64'(gpio_o), 64'(0));
    check("reset_status", 64'(irq_status_o), 64'(0));
    check("reset_irq_o", 64'(irq_o), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Rise on channel 0 with D=0: visible after the third edge, cleared by one pulse
    irq_en[0] = 1'b1;
    tick();
    gpio[0] = 1'b1;
    tick();
    check("t1_gpio0_edge0", 64'(gpio_o[0]), 64'(0));
    tick();
    check("t1_gpio0_edge1", 64'(gpio_o[0]), 64'(0));
    tick();
    check("t1_gpio0_edge2", 64'(gpio_o[0]), 64'(1));
    check("t1_irq_edge2", 64'(irq_o), 64'(1));
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("t1_irq_after_clr", 64'(irq_o), 64'(0));

    // D=4, both-edge type on channel 5: 3-cycle glitch
    dbc = 8'd4;
    de  = d_eff(dbc);
    set_type(5, 2'b10);
    irq_en = '0;
    tick();
    tick();
    gpio[5] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) gpio[5] = 1'b0;
      tick();
`ifdef PULP_IO_GPIO_DEBOUNCE_EN
      check("t2_glitch_gpio5", 64'(gpio_o[5]), 64'(0));
      check("t2_glitch_status5", 64'(irq_status_o[5]), 64'(0));
`endif
    end
    clr[5] = 1'b1;
    tick();
    clr[5] = 1'b0;
    tick();
    tick();

    // 6-cycle pulse on channel 5 is accepted on edge 2+D after the change
    gpio[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) gpio[5] = 1'b0;
      tick();
      check("t2_pulse_status5", 64'(irq_status_o[5]), 64'(i >= 2 + de));
    end
    repeat (10) tick();

    // Level type on channel 2 survives a clear pulse while the input stays high
    irq_en    = '0;
    irq_en[2] = 1'b1;
    set_type(2, 2'b11);
    gpio[2] = 1'b1;
    repeat (5 + de) tick();
    for (int i = 0; i < 6; i++) begin
      clr[2] = (i == 2);
      tick();
      check("t3_level_status2", 64'(irq_status_o[2]), 64'(1));
      check("t3_level_irq", 64'(irq_o), 64'(1));
    end
    clr[2]  = 1'b0;
    gpio[2] = 1'b0;
    set_type(2, 2'b01);
    repeat (8 + de) tick();
    clr = '1;
    tick();
    clr = '0;

    // Rise event on channel 7 coincides with a clear pulse: the event wins
    irq_en  = '0;
    gpio[7] = 1'b1;
    for (int i = 0; i <= 2 + de; i++) begin
      clr[7] = (i == 2 + de);
      tick();
    end
    clr[7] = 1'b0;
    check("t4_set_wins_status7", 64'(irq_status_o[7]), 64'(1));
    repeat (4) tick();

    // Disabled channel 3 ignores toggles, then accepts after re-enable with D=0
    dbc = 8'd0;
    de  = d_eff(dbc);
    repeat (4) tick();
    clr = '1;
    tick();
    clr = '0;
    irq_en    = '1;
    irq_en[3] = 1'b0;
    en[3]     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      gpio[3] = (i < 4) ? 1'b1 : ((i < 8) ? 1'b0 : 1'b1);
      tick();
      check("t5_disabled_gpio3", 64'(gpio_o[3]), 64'(0));
      check("t5_disabled_status3", 64'(irq_status_o[3]), 64'(0));
    end
    en[3] = 1'b1;
    tick();
    check("t5_reenable_status3", 64'(irq_status_o[3]), 64'(1));
    check("t5_reenable_gpio3", 64'(gpio_o[3]), 64'(1));
    check("t5_masked_irq", 64'(irq_o), 64'(0));

    // Asynchronous reset in the middle of a filter on channel 9
    dbc    = 8'd4;
    de     = d_eff(dbc);
    irq_en = '0;
    clr    = '1;
    tick();
    clr     = '0;
    gpio[9] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_gpio_o", 64'(gpio_o), 64'(0));
    check("t6_async_status", 64'(irq_status_o), 64'(0));
    check("t6_async_irq", 64'(irq_o), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i <= 3 + de; i++) begin
      tick();
      check("t6_rise_after_reset9", 64'(irq_status_o[9]), 64'(i >= 2 + de));
    end

    // Randomized traffic, including threshold and type changes mid-filter
    for (int c = 0; c < 400; c++) begin
      gpio = gpio ^ ($urandom & $urandom & $urandom);
      clr  = $urandom & $urandom & $urandom & $urandom;
      if (c % 50 == 0) en = $urandom | $urandom;
      if (c % 30 == 0) irq_en = $urandom;
      if (c % 40 == 0) typ = {$urandom, $urandom};
      if (c % 60 == 0) dbc = DW'($urandom_range(0, 5));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pulp_io_gpio_event.md
# pulp_io_gpio_event

Parametrised multi-channel GPIO input conditioner for the pulp-io peripheral subsystem. Each channel passes through a two-flop synchroniser, an optional debounce filter, and an edge/level event detector with sticky, software-clearable status. All channels are OR-reduced into one interrupt line. It sits between the pad-side GPIO inputs and the APB GPIO register file, which drives the configuration ports and reads the status ports.

## Interface
- NUM_GPIO, 32, number of independent input channels (1..64)
- DEBOUNCE_W, 8, width of the per-channel debounce counter and threshold
- clk_i  in  1  peripheral clock
- rst_ni  in  1  asynchronous active-low reset
- gpio_i  in  NUM_GPIO  raw, asynchronous pad inputs
- en_i  in  NUM_GPIO  per-channel sampling enable
- irq_en_i  in  NUM_GPIO  per-channel interrupt enable
- irq_type_i  in  2*NUM_GPIO  per-channel event type, bits [2k+1:2k]: 00 fall, 01 rise, 10 both edges, 11 level high
- debounce_cnt_i  in  DEBOUNCE_W  global debounce threshold D, in cycles
- irq_clr_i  in  NUM_GPIO  one-cycle pulse, clears the status bit
- gpio_o  out  NUM_GPIO  debounced stable value
- irq_status_o  out  NUM_GPIO  sticky event flags
- irq_o  out  1  |(irq_status_o & irq_en_i), combinational from registers

## Operation
- Sync: sync1_q <= gpio_i; sync_q <= sync1_q. Always runs, independent of en_i.
- Debounce, per channel k, with en_i[k]=1:
  - sync_q[k]==stable_q[k]: cnt_q[k] <= 0.
  - Mismatch and cnt_q[k]==debounce_cnt_i: stable_q[k] <= sync_q[k]; cnt_q[k] <= 0.
  - Mismatch otherwise: cnt_q[k] <= cnt_q[k]+1.
  - Saturation is impossible, because the count resets at the threshold. If D is lowered below the current count mid-filter, the comparison is equality-free: use cnt_q >= D.
- Disabled channel (en_i[k]=0): cnt_q[k] held at 0, stable_q[k] frozen, no events. On re-enable, the filter restarts from the frozen value.
- Event, per channel, computed on the cycle stable_q updates:
  - rise: stable 0->1.
  - fall: stable 1->0.
  - both: either transition.
  - level: stable_q==1 and en_i==1, evaluated every cycle.
- Status: status_q[k] <= event[k] | (status_q[k] & ~irq_clr_i[k]). Set wins over a simultaneous clear, so no event is lost.
- Status sets regardless of irq_en_i. irq_en_i gates only irq_o.
- A changed irq_type_i takes effect on the next stable_q transition. Already-set status is not altered.

## Timing
- Reset values: sync1_q, sync_q, stable_q, cnt_q and status_q are all 0. Therefore gpio_o=0, irq_status_o=0, irq_o=0.
- Input latency, with gpio_i changing before edge 0: sync_q changes after edge 1. stable_q and status change after edge 2+D. gpio_o and irq_o are visible after edge 2+D (D=0 gives 3-cycle latency).
- A glitch must persist as a mismatch for D+1 consecutive sync_q cycles to be accepted.
- Level type with a clear pulse while the input stays high: status re-sets on the same edge, and irq_o stays 1.
- Reset mid-filter: all counters and flags clear asynchronously. A high input after reset produces a rise event after 3+D cycles.

## Configuration
- PULP_IO_GPIO_DEBOUNCE_EN defined: debounce counters are instantiated as above.
- PULP_IO_GPIO_DEBOUNCE_EN undefined: no cnt_q registers. stable_q <= sync_q every cycle when enabled, which is behaviourally identical to D=0. debounce_cnt_i is present but ignored.

## Test plan
- Reset release with gpio_i=0, NUM_GPIO=32:
  - gpio_i[0] 0->1 with D=0, type rise, irq_en on.
  - Expected: gpio_o[0]=1 and irq_o=1 exactly 3 cycles after the change. irq_clr_i[0] pulse drops irq_o the next cycle.
- D=4, 3-cycle high glitch on gpio_i[5] (type both): gpio_o[5] stays 0 and no status.
- Same setup, 6-cycle high pulse on gpio_i[5]: status sets 7 cycles after the rising change.
- Level type on channel 2, input held high, irq_clr_i[2] pulsed: irq_status_o[2] never observed 0, and irq_o stays 1.
- Simultaneous rise event and irq_clr_i on channel 7: status_q[7]=1 afterwards.
- en_i[3]=0 while gpio_i[3] toggles 0->1->0->1:
  - Expected: gpio_o[3] frozen at 0 and no status.
  - Re-enable with D=0: rise event after 1 cycle.
  - With irq_en_i[3]=0, status sets but irq_o stays 0.
